iterative_multiplier: RTL and testbench

ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_step.sv | 22 ++
 rtl/iterative_multiplier.sv | 103 ++++++++++
 tb/tb_iterative_multiplier.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier.
// State encoding and iteration-count helper.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int iter_of(
    input int width,
    input int bpc
  );
    return width / bpc;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One iteration of shift-and-add: adds the partial product of
// the multiplicand and one multiplier digit at the given offset.
module mult_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  localparam int SW            = $clog2(2 * WIDTH)
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  input  logic [SW-1:0]             shamt,
  output logic [2*WIDTH-1:0]        acc_nxt
);

  logic [2*WIDTH-1:0] pp;

  assign pp = {{WIDTH{1'b0}}, mcand}
            * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, digit};

  assign acc_nxt = acc + (pp << shamt);

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle signed/unsigned multiplier retiring
// BITS_PER_CYCLE multiplier bits per clock.
module iterative_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               busy
);

  import mult_pkg::*;

  localparam int ITER = iter_of(WIDTH, BITS_PER_CYCLE);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SW   = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4) ||
      (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("iterative_multiplier: illegal BITS_PER_CYCLE");
  end

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CW-1:0]      cnt;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // -2^(WIDTH-1) negates to itself, which is the right unsigned magnitude
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign shamt = SW'(cnt) * SW'(BITS_PER_CYCLE);

  mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .digit   (mplier[BITS_PER_CYCLE-1:0]),
    .shamt   (shamt),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      y      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc    <= acc_nxt;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            y     <= neg ? -acc_nxt : acc_nxt;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench: vector tables, corner sequences and
// random ops against an arithmetic reference model.
module tb_iterative_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, signed_mode;
  logic [31:0] a, b;
  logic        out_valid, out_ready, busy;
  logic [63:0] y;

  logic        in_valid_h, in_ready_h, signed_mode_h;
  logic [15:0] a_h, b_h;
  logic        out_valid_h, out_ready_h, busy_h;
  logic [31:0] y_h;

  int checks = 0;
  int errors = 0;
  int acc_n  = 0;
  int res_n  = 0;

  always #5 clk = ~clk;

  iterative_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy)
  );

  iterative_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_h), .in_ready(in_ready_h),
    .signed_mode(signed_mode_h), .a(a_h), .b(b_h),
    .out_valid(out_valid_h), .out_ready(out_ready_h),
    .y(y_h), .busy(busy_h)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_n++;
      if (out_valid && out_ready) res_n++;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] y;
  } vec_t;

  function automatic logic [63:0] ref32(
    input logic [31:0] x, input logic [31:0] z, input logic sm
  );
    if (sm) return 64'(longint'($signed(x)) * longint'($signed(z)));
    return {32'b0, x} * {32'b0, z};
  endfunction

  function automatic logic [31:0] ref16(
    input logic [15:0] x, input logic [15:0] z, input logic sm
  );
    if (sm) return 32'(int'($signed(x)) * int'($signed(z)));
    return {16'b0, x} * {16'b0, z};
  endfunction

  task automatic check(
    input string nm, input logic [63:0] act, input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(
    input logic [31:0] av, input logic [31:0] bv, input logic smv,
    input int stall, output logic [63:0] yo, output int lat
  );
    int w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = av; b = bv; signed_mode = smv;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; signed_mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    repeat (stall) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      step();
    end
    in_valid = 1'b0;
    yo = y;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run16(
    input logic [15:0] av, input logic [15:0] bv, input logic smv,
    input int stall, output logic [31:0] yo, output int lat
  );
    int w = 0;
    while (!in_ready_h && w < 50) begin step(); w++; end
    if (!in_ready_h) check("ready16_timeout", 64'(in_ready_h), 64'd1);
    in_valid_h = 1'b1; a_h = av; b_h = bv; signed_mode_h = smv;
    step();
    in_valid_h = 1'b0;
    a_h = 16'($urandom); b_h = 16'($urandom);
    lat = 0;
    while (!out_valid_h && lat < 200) begin step(); lat++; end
    repeat (stall) step();
    yo = y_h;
    out_ready_h = 1'b1;
    step();
    out_ready_h = 1'b0;
  endtask

  vec_t        tbl[10];
  logic [63:0] yr;
  logic [31:0] yr16;
  int          lat;
  int          a0, r0;
  logic [31:0] ra, rb;
  logic        rs;
  logic [15:0] ha, hb;

  initial begin
    tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    tbl[1] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1};
    tbl[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000};
    tbl[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 64'h0};
    tbl[4] = '{32'h00000007, 32'h00000006, 1'b0, 64'd42};
    tbl[5] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    tbl[6] = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000};
    tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1};
    tbl[8] = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};
    tbl[9] = '{32'h00000007, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFF9};

    rst = 1'b1;
    in_valid = 0; signed_mode = 0; a = 0; b = 0; out_ready = 0;
    in_valid_h = 0; signed_mode_h = 0; a_h = 0; b_h = 0;
    out_ready_h = 0;
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_y", y, 64'd0);
    check("rst_y16", 64'(y_h), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run32(tbl[i].a, tbl[i].b, tbl[i].sm, i % 3, yr, lat);
      check($sformatf("vec%0d_y", i), yr, tbl[i].y);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd32);
    end

    // result held under back-pressure, new requests ignored
    in_valid = 1'b1; a = 32'd7; b = 32'd6; signed_mode = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    check("stall_lat", 64'(lat), 64'd32);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      step();
      check("stall_y", y, 64'd42);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_y_hold", y, 64'd42);

    // reset abandons an operation mid-flight
    in_valid = 1'b1; a = '1; b = '1; signed_mode = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_y", y, 64'd0);
    run32(32'd7, 32'd6, 1'b0, 0, yr, lat);
    check("post_rst_y", yr, 64'd42);
    check("post_rst_lat", 64'(lat), 64'd32);

    run16(16'h1234, 16'h5678, 1'b0, 0, yr16, lat);
    check("w16_y", 64'(yr16), 64'h06260060);
    check("w16_lat", 64'(lat), 64'd4);
    run16(16'h8000, 16'h8000, 1'b1, 2, yr16, lat);
    check("w16_minmin", 64'(yr16), 64'h40000000);
    run16(16'hFFFD, 16'h0005, 1'b1, 1, yr16, lat);
    check("w16_neg", 64'(yr16), 64'hFFFFFFF1);
    run16(16'hFFFF, 16'hFFFF, 1'b0, 0, yr16, lat);
    check("w16_max", 64'(yr16), 64'hFFFE0001);
    for (int i = 0; i < 200; i++) begin
      ha = 16'($urandom); hb = 16'($urandom); rs = 1'($urandom);
      run16(ha, hb, rs, $urandom_range(0, 2), yr16, lat);
      check("w16_rand_y", 64'(yr16), 64'(ref16(ha, hb, rs)));
      check("w16_rand_lat", 64'(lat), 64'd4);
    end

    a0 = acc_n; r0 = res_n;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 7 == 0) ra = 32'h80000000;
      run32(ra, rb, rs, $urandom_range(0, 3), yr, lat);
      check("rand_y", yr, ref32(ra, rb, rs));
      check("rand_lat", 64'(lat), 64'd32);
    end
    check("rand_accepts", 64'(acc_n - a0), 64'd1000);
    check("rand_results", 64'(res_n - r0), 64'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
